// File: rtl/melody_seq.sv
// melody_seq -- steps through a fixed 32-entry song ROM at a programmable
// beat rate. Each step it presents a half-period divider and a signed
// amplitude pair to the square-wave note generator.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   play_pause, stop      one-cycle transport pulses (stop has priority)
//   loop_en               1 = wrap at song end, 0 = stop at song end
//   vol_up, vol_down      one-cycle volume pulses, saturating 0..7
//   oct_up, oct_down      one-cycle octave pulses, saturating 0..2
//   mute                  level, forces zero amplitude
//   note_div              half-period divider (generator toggles every note_div+1)
//   volumn_up/volumn_down +A / -A amplitude, two's complement
//   playing, beat_idx, vol_level, octave   status
//
// state | meaning
// ------+---------------------------------------------------------------
// STOP  | idle at index 0, outputs silent, note_div = 0
// PLAY  | tick counter running, index advances every T cycles
// PAUSE | index and tick held, amplitude silent, note_div held

module melody_seq #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BEAT_HZ  = 8,
   parameter int SONG_LEN = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        play_pause,
   input  logic        stop,
   input  logic        loop_en,
   input  logic        vol_up,
   input  logic        vol_down,
   input  logic        oct_up,
   input  logic        oct_down,
   input  logic        mute,
   output logic [21:0] note_div,
   output logic [15:0] volumn_up,
   output logic [15:0] volumn_down,
   output logic        playing,
   output logic [4:0]  beat_idx,
   output logic [2:0]  vol_level,
   output logic [1:0]  octave
);

   localparam int T      = CLK_FREQ / BEAT_HZ;
   localparam int TICK_W = (T > 1) ? $clog2(T) : 1;
   localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(T - 1);
   localparam logic [4:0] IDX_LAST = 5'(SONG_LEN - 1);

   typedef enum logic [1:0] {
      S_STOP  = 2'd0,
      S_PLAY  = 2'd1,
      S_PAUSE = 2'd2
   } state_t;

   state_t state;

   // Divider per (octave, note code). Low octave halves the mid frequency,
   // so floor(CLK/(2*f_mid/2)) = floor(CLK/f_mid); each octave up doubles
   // the divisor. Code 0 (rest) and octave 3 map to 0.
   function automatic logic [21:0] note_div_of(input int code, input int oct);
      int f_mid;
      int q;
      case (code)
         1:       f_mid = 262;
         2:       f_mid = 294;
         3:       f_mid = 330;
         4:       f_mid = 349;
         5:       f_mid = 392;
         6:       f_mid = 440;
         7:       f_mid = 494;
         default: f_mid = 0;
      endcase
      if (f_mid == 0 || oct > 2) begin
         return 22'd0;
      end
      q = CLK_FREQ / (f_mid << oct);
      return 22'(q - 1);
   endfunction

   logic [21:0] div_tbl [4][8];

   for (genvar o = 0; o < 4; o++) begin : g_oct
      for (genvar c = 0; c < 8; c++) begin : g_code
         assign div_tbl[o][c] = note_div_of(c, o);
      end
   end

   logic [TICK_W-1:0] tick_cnt;
   logic [TICK_W-1:0] step_tick;
   logic [4:0]        step_idx;
   logic              step_end;
   logic              advance;
   logic [2:0]        note_code;
   logic              sounding;
   logic [15:0]       amp;

   // Song ROM: every eighth entry is a rest, the rest cycle C..B.
   assign note_code = (beat_idx[2:0] == 3'd7) ? 3'd0 : beat_idx[2:0] + 3'd1;

   // Tick counter runs down; terminal count 0 reloads and advances the index.
   // The resume edge counts as a PLAY cycle so each index still spans
   // exactly T cycles of PLAY when paused mid-step.
   always_comb begin
      step_tick = tick_cnt - 1'b1;
      step_idx  = beat_idx;
      step_end  = 1'b0;
      if (tick_cnt == '0) begin
         step_tick = TICK_LOAD;
         step_idx  = beat_idx + 5'd1;
         step_end  = (beat_idx == IDX_LAST) && !loop_en;
      end
      advance  = ((state == S_PLAY) && !play_pause) ||
                 ((state == S_PAUSE) && play_pause);
      sounding = (state == S_PLAY) && (note_code != 3'd0) && !mute &&
                 (vol_level != 3'd0);
      amp      = {2'b00, vol_level, 11'd0};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_STOP;
         tick_cnt    <= TICK_LOAD;
         beat_idx    <= 5'd0;
         playing     <= 1'b0;
         vol_level   <= 3'd3;
         octave      <= 2'd1;
         note_div    <= 22'd0;
         volumn_up   <= 16'd0;
         volumn_down <= 16'd0;
      end else begin
         if (stop) begin
            state    <= S_STOP;
            playing  <= 1'b0;
            beat_idx <= 5'd0;
            tick_cnt <= TICK_LOAD;
         end else begin
            case (state)
               S_STOP: begin
                  if (play_pause) begin
                     state    <= S_PLAY;
                     playing  <= 1'b1;
                     beat_idx <= 5'd0;
                     tick_cnt <= TICK_LOAD;
                  end
               end
               S_PLAY: begin
                  if (play_pause) begin
                     state   <= S_PAUSE;
                     playing <= 1'b0;
                  end
               end
               S_PAUSE: begin
                  if (play_pause) begin
                     state   <= S_PLAY;
                     playing <= 1'b1;
                  end
               end
               default: begin
                  state   <= S_STOP;
                  playing <= 1'b0;
               end
            endcase

            if (advance) begin
               tick_cnt <= step_tick;
               beat_idx <= step_idx;
               if (step_end) begin
                  state    <= S_STOP;
                  playing  <= 1'b0;
                  beat_idx <= 5'd0;
               end
            end
         end

         if (vol_up && !vol_down && vol_level != 3'd7) begin
            vol_level <= vol_level + 3'd1;
         end else if (vol_down && !vol_up && vol_level != 3'd0) begin
            vol_level <= vol_level - 3'd1;
         end

         if (oct_up && !oct_down && octave < 2'd2) begin
            octave <= octave + 2'd1;
         end else if (oct_down && !oct_up && octave != 2'd0) begin
            octave <= octave - 2'd1;
         end

         case (state)
            S_PLAY:  note_div <= div_tbl[octave][note_code];
            S_PAUSE: note_div <= note_div;
            default: note_div <= 22'd0;
         endcase
         volumn_up   <= sounding ? amp : 16'd0;
         volumn_down <= sounding ? (16'd0 - amp) : 16'd0;
      end
   end

endmodule

// File: tb/tb_melody_seq.sv
// Directed bench for melody_seq at T = 10 cycles per step.
module tb_melody_seq;

   logic        clk;
   logic        rst_n;
   logic        play_pause;
   logic        stop;
   logic        loop_en;
   logic        vol_up;
   logic        vol_down;
   logic        oct_up;
   logic        oct_down;
   logic        mute;
   logic [21:0] note_div;
   logic [15:0] volumn_up;
   logic [15:0] volumn_down;
   logic        playing;
   logic [4:0]  beat_idx;
   logic [2:0]  vol_level;
   logic [1:0]  octave;

   int tests = 0;
   int fails = 0;

   // mid-octave dividers at 100 MHz, indexed by note code (0 = rest)
   int mid_div [8] = '{0, 190838, 170067, 151514, 143265, 127550, 113635, 101213};

   melody_seq #(
      .CLK_FREQ(100_000_000),
      .BEAT_HZ (10_000_000),
      .SONG_LEN(32)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .play_pause (play_pause),
      .stop       (stop),
      .loop_en    (loop_en),
      .vol_up     (vol_up),
      .vol_down   (vol_down),
      .oct_up     (oct_up),
      .oct_down   (oct_down),
      .mute       (mute),
      .note_div   (note_div),
      .volumn_up  (volumn_up),
      .volumn_down(volumn_down),
      .playing    (playing),
      .beat_idx   (beat_idx),
      .vol_level  (vol_level),
      .octave     (octave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_pp();
      play_pause = 1'b1;
      cyc(1);
      play_pause = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; play_pause = 0; stop = 0; loop_en = 1; vol_up = 0;
      vol_down = 0; oct_up = 0; oct_down = 0; mute = 0;
      #22 rst_n = 1'b1;
      #1;
      tests++; if (note_div !== 22'd0) begin fails++; $display("FAIL reset_note_div: got %0d want 0", note_div); end
      tests++; if (volumn_up !== 16'd0) begin fails++; $display("FAIL reset_vol_up: got %h want 0000", volumn_up); end
      tests++; if (volumn_down !== 16'd0) begin fails++; $display("FAIL reset_vol_down: got %h want 0000", volumn_down); end
      tests++; if (playing !== 1'b0) begin fails++; $display("FAIL reset_playing: got %b want 0", playing); end
      tests++; if (beat_idx !== 5'd0) begin fails++; $display("FAIL reset_idx: got %0d want 0", beat_idx); end
      tests++; if (vol_level !== 3'd3) begin fails++; $display("FAIL reset_vol_level: got %0d want 3", vol_level); end
      tests++; if (octave !== 2'd1) begin fails++; $display("FAIL reset_octave: got %0d want 1", octave); end
      pulse_pp();
      tests++; if (playing !== 1'b1) begin fails++; $display("FAIL start_playing: got %b want 1", playing); end
      cyc(1);
      tests++; if (note_div !== 22'd190838) begin fails++; $display("FAIL start_note_div: got %0d want 190838", note_div); end
      tests++; if (volumn_up !== 16'h1800) begin fails++; $display("FAIL start_vol_up: got %h want 1800", volumn_up); end
      tests++; if (volumn_down !== 16'hE800) begin fails++; $display("FAIL start_vol_down: got %h want e800", volumn_down); end
   endtask

   task automatic test_stepping();
      int code;
      logic [15:0] exp_up, exp_dn;
      pulse_stop();
      loop_en = 1'b1;
      pulse_pp();
      for (int n = 0; n < 32; n++) begin
         code   = (n % 8 == 7) ? 0 : (n % 8) + 1;
         exp_up = (code == 0) ? 16'h0000 : 16'h1800;
         exp_dn = (code == 0) ? 16'h0000 : 16'hE800;
         cyc(1);
         tests++; if (note_div !== 22'(mid_div[code])) begin fails++; $display("FAIL step_note_div idx %0d: got %0d want %0d", n, note_div, mid_div[code]); end
         tests++; if (volumn_up !== exp_up) begin fails++; $display("FAIL step_vol_up idx %0d: got %h want %h", n, volumn_up, exp_up); end
         tests++; if (volumn_down !== exp_dn) begin fails++; $display("FAIL step_vol_down idx %0d: got %h want %h", n, volumn_down, exp_dn); end
         cyc(8);
         tests++; if (beat_idx !== 5'(n)) begin fails++; $display("FAIL step_hold idx %0d: got %0d", n, beat_idx); end
         cyc(1);
         tests++; if (beat_idx !== 5'((n + 1) % 32)) begin fails++; $display("FAIL step_adv after %0d: got %0d want %0d", n, beat_idx, (n + 1) % 32); end
      end
      tests++; if (playing !== 1'b1) begin fails++; $display("FAIL loop_playing: got %b want 1", playing); end
      pulse_stop();
      tests++; if (playing !== 1'b0) begin fails++; $display("FAIL stop_playing: got %b want 0", playing); end
   endtask

   task automatic test_song_end();
      loop_en = 1'b0;
      pulse_pp();
      cyc(319);
      tests++; if (beat_idx !== 5'd31 || playing !== 1'b1) begin fails++; $display("FAIL end_last_step: got idx %0d playing %b want 31/1", beat_idx, playing); end
      cyc(1);
      tests++; if (playing !== 1'b0) begin fails++; $display("FAIL end_playing: got %b want 0", playing); end
      tests++; if (beat_idx !== 5'd0) begin fails++; $display("FAIL end_idx: got %0d want 0", beat_idx); end
      cyc(1);
      tests++; if (volumn_up !== 16'd0 || volumn_down !== 16'd0) begin fails++; $display("FAIL end_silence: got %h/%h want 0/0", volumn_up, volumn_down); end
      tests++; if (note_div !== 22'd0) begin fails++; $display("FAIL end_note_div: got %0d want 0", note_div); end
      loop_en = 1'b1;
   endtask

   task automatic test_pause();
      pulse_pp();
      cyc(34);
      tests++; if (beat_idx !== 5'd3) begin fails++; $display("FAIL pause_pre_idx: got %0d want 3", beat_idx); end
      pulse_pp();
      tests++; if (playing !== 1'b0) begin fails++; $display("FAIL pause_playing: got %b want 0", playing); end
      cyc(1);
      tests++; if (note_div !== 22'd143265) begin fails++; $display("FAIL pause_note_div: got %0d want 143265", note_div); end
      tests++; if (volumn_up !== 16'd0) begin fails++; $display("FAIL pause_silence: got %h want 0000", volumn_up); end
      cyc(50);
      tests++; if (beat_idx !== 5'd3) begin fails++; $display("FAIL pause_hold_idx: got %0d want 3", beat_idx); end
      tests++; if (note_div !== 22'd143265) begin fails++; $display("FAIL pause_hold_div: got %0d want 143265", note_div); end
      pulse_pp();
      tests++; if (playing !== 1'b1) begin fails++; $display("FAIL resume_playing: got %b want 1", playing); end
      cyc(4);
      tests++; if (beat_idx !== 5'd3) begin fails++; $display("FAIL resume_early: got %0d want 3", beat_idx); end
      cyc(1);
      tests++; if (beat_idx !== 5'd4) begin fails++; $display("FAIL resume_adv: got %0d want 4", beat_idx); end
      stop = 1'b1; play_pause = 1'b1;
      cyc(1);
      stop = 1'b0; play_pause = 1'b0;
      tests++; if (playing !== 1'b0 || beat_idx !== 5'd0) begin fails++; $display("FAIL stop_priority: got playing %b idx %0d want 0/0", playing, beat_idx); end
      cyc(1);
      tests++; if (note_div !== 22'd0) begin fails++; $display("FAIL stop_note_div: got %0d want 0", note_div); end
   endtask

   task automatic test_volume();
      pulse_pp();
      for (int i = 0; i < 5; i++) begin
         vol_up = 1'b1; cyc(1); vol_up = 1'b0;
      end
      tests++; if (vol_level !== 3'd7) begin fails++; $display("FAIL vol_max: got %0d want 7", vol_level); end
      cyc(1);
      tests++; if (volumn_up !== 16'h3800 || volumn_down !== 16'hC800) begin fails++; $display("FAIL vol_max_amp: got %h/%h want 3800/c800", volumn_up, volumn_down); end
      for (int i = 0; i < 8; i++) begin
         vol_down = 1'b1; cyc(1); vol_down = 1'b0;
      end
      tests++; if (vol_level !== 3'd0) begin fails++; $display("FAIL vol_min: got %0d want 0", vol_level); end
      cyc(1);
      tests++; if (volumn_up !== 16'd0 || volumn_down !== 16'd0) begin fails++; $display("FAIL vol_min_amp: got %h/%h want 0/0", volumn_up, volumn_down); end
      tests++; if (note_div !== 22'd170067) begin fails++; $display("FAIL vol_min_div: got %0d want 170067", note_div); end
      vol_up = 1'b1; cyc(1); vol_up = 1'b0;
      vol_up = 1'b1; vol_down = 1'b1; cyc(1); vol_up = 1'b0; vol_down = 1'b0;
      tests++; if (vol_level !== 3'd1) begin fails++; $display("FAIL vol_both: got %0d want 1", vol_level); end
      cyc(1);
      tests++; if (volumn_up !== 16'h0800 || volumn_down !== 16'hF800) begin fails++; $display("FAIL vol_one_amp: got %h/%h want 0800/f800", volumn_up, volumn_down); end
      pulse_stop();
   endtask

   task automatic test_mute();
      mute = 1'b1;
      pulse_pp();
      cyc(1);
      tests++; if (note_div !== 22'd190838) begin fails++; $display("FAIL mute_div0: got %0d want 190838", note_div); end
      tests++; if (volumn_up !== 16'd0) begin fails++; $display("FAIL mute_amp0: got %h want 0000", volumn_up); end
      cyc(10);
      tests++; if (beat_idx !== 5'd1) begin fails++; $display("FAIL mute_idx: got %0d want 1", beat_idx); end
      tests++; if (note_div !== 22'd170067) begin fails++; $display("FAIL mute_div1: got %0d want 170067", note_div); end
      tests++; if (volumn_up !== 16'd0 || volumn_down !== 16'd0) begin fails++; $display("FAIL mute_amp1: got %h/%h want 0/0", volumn_up, volumn_down); end
      mute = 1'b0;
      cyc(1);
      tests++; if (volumn_up !== 16'h0800) begin fails++; $display("FAIL unmute_amp: got %h want 0800", volumn_up); end
      pulse_stop();
   endtask

   task automatic test_octave();
      pulse_pp();
      cyc(50);
      tests++; if (beat_idx !== 5'd5) begin fails++; $display("FAIL oct_idx: got %0d want 5", beat_idx); end
      oct_up = 1'b1; cyc(1); oct_up = 1'b0;
      tests++; if (octave !== 2'd2) begin fails++; $display("FAIL oct_up: got %0d want 2", octave); end
      tests++; if (note_div !== 22'd113635) begin fails++; $display("FAIL oct_lag: got %0d want 113635", note_div); end
      cyc(1);
      tests++; if (note_div !== 22'd56817) begin fails++; $display("FAIL oct_high_div: got %0d want 56817", note_div); end
      oct_up = 1'b1; cyc(1); oct_up = 1'b0;
      tests++; if (octave !== 2'd2) begin fails++; $display("FAIL oct_sat_high: got %0d want 2", octave); end
      for (int i = 0; i < 2; i++) begin
         oct_down = 1'b1; cyc(1); oct_down = 1'b0;
      end
      tests++; if (octave !== 2'd0) begin fails++; $display("FAIL oct_low: got %0d want 0", octave); end
      cyc(1);
      tests++; if (note_div !== 22'd227271) begin fails++; $display("FAIL oct_low_div: got %0d want 227271", note_div); end
      oct_down = 1'b1; cyc(1); oct_down = 1'b0;
      tests++; if (octave !== 2'd0) begin fails++; $display("FAIL oct_sat_low: got %0d want 0", octave); end
      cyc(1);
      tests++; if (note_div !== 22'd227271) begin fails++; $display("FAIL oct_sat_div: got %0d want 227271", note_div); end
      oct_up = 1'b1; oct_down = 1'b1; cyc(1); oct_up = 1'b0; oct_down = 1'b0;
      tests++; if (octave !== 2'd0) begin fails++; $display("FAIL oct_both: got %0d want 0", octave); end
   endtask

   task automatic test_reset_mid();
      cyc(3);
      #3 rst_n = 1'b0;
      #1;
      tests++; if (playing !== 1'b0 || beat_idx !== 5'd0) begin fails++; $display("FAIL rst_mid_state: got playing %b idx %0d want 0/0", playing, beat_idx); end
      tests++; if (vol_level !== 3'd3 || octave !== 2'd1) begin fails++; $display("FAIL rst_mid_cfg: got vol %0d oct %0d want 3/1", vol_level, octave); end
      tests++; if (note_div !== 22'd0) begin fails++; $display("FAIL rst_mid_div: got %0d want 0", note_div); end
      #1 rst_n = 1'b1;
      cyc(2);
      tests++; if (playing !== 1'b0) begin fails++; $display("FAIL rst_mid_release: got %b want 0", playing); end
   endtask

   initial begin
      test_reset();
      test_stepping();
      test_song_end();
      test_pause();
      test_volume();
      test_mute();
      test_octave();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/melody_seq.md
# melody_seq

Melody sequencer that drives the square-wave note generator in the audio path. It steps through a fixed 32-entry song ROM at a programmable beat rate and handles play/pause/stop, volume and octave control. Each step it presents a half-period divider `note_div` and a signed amplitude pair `volumn_up`/`volumn_down`. These feed the note generator directly; the note generator's outputs go to the speaker serializer.

## Interface

- `CLK_FREQ`, 100_000_000, system clock frequency in Hz.
- `BEAT_HZ`, 8, song step rate in Hz. Must divide `CLK_FREQ` to ≥ 2 cycles per step.
- `SONG_LEN`, 32, number of ROM entries. Fixed at 32; the index is 5 bits.

Ports:

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `play_pause`  in  1  one-cycle pulse; start, pause or resume
- `stop`  in  1  one-cycle pulse; return to STOP at index 0
- `loop_en`  in  1  level; 1 = wrap at song end, 0 = stop at song end
- `vol_up`, `vol_down`  in  1  one-cycle pulses; volume level ±1
- `oct_up`, `oct_down`  in  1  one-cycle pulses; octave ±1
- `mute`  in  1  level; forces zero amplitude
- `note_div`  out  22  half-period divider; note generator toggles every `note_div`+1 cycles
- `volumn_up`  out  16  positive amplitude, two's complement
- `volumn_down`  out  16  negative amplitude, two's complement
- `playing`  out  1  high in PLAY
- `beat_idx`  out  5  current ROM index
- `vol_level`  out  3  current volume level 0–7
- `octave`  out  2  0 = low, 1 = mid, 2 = high

## Operation

- **FSM states:** STOP, PLAY, PAUSE.
  - STOP + `play_pause` → PLAY. Index = 0, tick counter = 0.
  - PLAY + `play_pause` → PAUSE. Index and tick counter hold.
  - PAUSE + `play_pause` → PLAY. Resumes from the held tick count.
  - `stop` in any state → STOP. Index and tick counter clear.
  - `stop` has priority over a simultaneous `play_pause`.
- **Tick counter:** counts 0..T−1 in PLAY only, where T = `CLK_FREQ`/`BEAT_HZ`. At T−1 it wraps to 0 and the index advances.
- **Song end:** when the index advances from 31:
  - `loop_en`=1 → index 0, remain in PLAY.
  - `loop_en`=0 → STOP, index 0.
- **ROM content:** entry i has note code c = (i mod 8)+1 when (i mod 8) < 7, else 0 (rest).
  - Codes 1–7 = C D E F G A B.
  - Mid-octave frequencies: 262, 294, 330, 349, 392, 440, 494 Hz.
- **Divider value:** f_oct = f_mid/2 (low), f_mid (mid), 2·f_mid (high). `note_div` = floor(`CLK_FREQ`/(2·f_oct)) − 1. Computed as elaborated constants, no runtime divider.
  - Examples at 100 MHz, note A: low = 227271, mid = 113635, high = 56817.
- **Amplitude:** A = `vol_level` × 16'h0800. `volumn_up` = A, `volumn_down` = −A (two's complement).
- **Silence:** `volumn_up` = `volumn_down` = 0 when any of these holds: not PLAY, rest, `mute`=1, `vol_level`=0.
  - On a rest or in STOP, `note_div` = 0.
  - In PAUSE, `note_div` holds its last value.
- **Volume:** saturates at 0 and 7; reset value 3.
- **Octave:** saturates at 0 and 2; reset value 1.
- **Simultaneous up and down** (`vol_up`+`vol_down`, or `oct_up`+`oct_down`): no change.
- Volume and octave changes are accepted in every state.

## Timing

- **Reset values:** `note_div`=0, `volumn_up`=0, `volumn_down`=0, `playing`=0, `beat_idx`=0, `vol_level`=3, `octave`=1. State = STOP, tick = 0.
- **State register:** `play_pause`/`stop` sampled at edge k; state and `playing` change at edge k (visible after edge k).
- **Outputs:** `note_div`, `volumn_up` and `volumn_down` are registered from the current state, index, volume and octave. They lag those by one cycle.
- **Step period:** exactly T cycles per index while in PLAY. PAUSE time is excluded.
- **Timing of control pulses:**
  - Volume and octave pulses take effect on the next edge.
  - The resulting output change appears one cycle later.
- **Reset mid-song:** asserting `rst_n` low clears everything immediately (asynchronous). Deassertion returns to STOP.

## Test plan

Configuration for all scenarios: `CLK_FREQ`=100_000_000, `BEAT_HZ`=10_000_000 (T=10).

- **Reset:** check every output against the reset-value list in Timing. Pulse `play_pause` → `playing`=1; one cycle later `note_div`=190838 (C mid) and `volumn_up`=16'h1800, `volumn_down`=16'hE800.
- **Stepping and loop:** play with `loop_en`=1. `beat_idx` advances every 10 cycles. At idx 7 the outputs are `volumn_*`=0 and `note_div`=0. After idx 31 the index wraps to 0 and `playing` stays 1.
- **Song end without loop:** `loop_en`=0 → after idx 31 completes, `playing`=0, `beat_idx`=0, `volumn_*`=0.
- **Pause and priority:**
  - Pause at idx 3, tick 4; hold 50 cycles → `beat_idx` stays 3.
  - Resume → idx 4 arrives after 5 more cycles.
  - Assert `stop` and `play_pause` in the same cycle → STOP.
- **Volume:**
  - Five `vol_up` pulses → `vol_level`=7, `volumn_up`=16'h3800, `volumn_down`=16'hC800.
  - Eight `vol_down` pulses → 0 and silence.
  - `vol_up` and `vol_down` together → no change.
  - `mute`=1 → silence while `note_div` continues stepping.
- **Octave:**
  - `oct_up` at idx 5 → `note_div`=56817.
  - Two `oct_down` pulses → 227271.
  - A third `oct_down` → remains at octave 0.
